serial_subtractor: RTL

Bit-serial two's-complement subtractor computing a − b − borrow_in over WIDTH clock cycles, one bit per cycle, using a single registered borrow. It is the inverse-direction companion to the team's combinational ripple adders: the same per-bit cell structure, but subtracting and time-multiplexed onto one cell. It sits behind a valid/ready handshake on both sides, so it can drop into any streaming datapath that needs low-area subtraction.

---
 rtl/serial_arith_pkg.sv | 23 ++
 rtl/full_subtractor_dataflow.sv | 32 +++
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
//
// Purpose:
//   Shared definitions for the bit-serial arithmetic blocks. It holds the
//   handshake/sequencing state type and the default operand width.
//
// Contents:
//   DEFAULT_WIDTH  default operand/result width in bits
//   sub_state_t    IDLE (accepting operands), SHIFT (one bit per cycle),
//                  DONE (result held until the consumer takes it)
// ---------------------------------------------------------------------------
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor_dataflow.sv
// ---------------------------------------------------------------------------
// full_subtractor_dataflow
//
// Purpose:
//   One-bit full subtractor cell, pure dataflow. It computes
//   a - b - borrow_in for a single bit position. It is the subtracting twin
//   of the ripple-adder full-adder cell.
//
// Ports:
//   a           input   minuend bit
//   b           input   subtrahend bit
//   borrow_in   input   borrow from the next lower bit
//   diff        output  difference bit
//   borrow_out  output  borrow into the next higher bit
// ---------------------------------------------------------------------------
module full_subtractor_dataflow
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  // A borrow is generated when a=0 and b=1. An incoming borrow is passed
  // through when a and b are equal, because then a-b is zero and the
  // borrow has to ripple onward.
  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule : full_subtractor_dataflow

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   Bit-serial two's-complement subtractor. It computes a - b - borrow_in
//   over WIDTH cycles using a single full-subtractor cell and one registered
//   borrow. Operands are captured on an input valid/ready handshake. The
//   result is presented on an output valid/ready handshake. A new operation
//   is accepted only after the previous result has been taken.
//
// Parameters:
//   WIDTH       operand and result width in bits (>= 2)
//
// Ports:
//   clk         input   rising-edge clock
//   rst_n       input   asynchronous active-low reset
//   in_valid    input   a/b/borrow_in are valid
//   in_ready    output  block can accept operands (high in IDLE)
//   a           input   minuend
//   b           input   subtrahend
//   borrow_in   input   borrow into bit 0
//   out_valid   output  diff/borrow_out/overflow are valid (high in DONE)
//   out_ready   input   consumer accepts the result
//   diff        output  a - b - borrow_in modulo 2^WIDTH
//   borrow_out  output  borrow out of the MSB (unsigned a < b + borrow_in)
//   overflow    output  signed overflow of the subtraction
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  sub_state_t       state_q;
  sub_state_t       state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [IDX_W-1:0] idx_q;

  logic             cell_a;
  logic             cell_b;
  logic             cell_diff;
  logic             cell_borrow;

  logic             capture;
  logic             last_bit;
  logic             release_result;

  // Handshake qualifiers. in_ready and out_valid come only from the state
  // register. This keeps in_valid and out_ready off any combinational path
  // to the handshake outputs.
  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign capture        = in_ready & in_valid;
  assign last_bit       = (state_q == SHIFT) && (idx_q == LAST_IDX);
  assign release_result = out_valid & out_ready;

  // The single subtractor cell is fed by the captured operand bits at the
  // current index. The registered borrow carries between cycles.
  assign cell_a = a_q[idx_q];
  assign cell_b = b_q[idx_q];

  full_subtractor_dataflow u_cell (
    .a          (cell_a),
    .b          (cell_b),
    .borrow_in  (br_q),
    .diff       (cell_diff),
    .borrow_out (cell_borrow)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. SHIFT lasts exactly WIDTH cycles and leaves after
  // the MSB has been processed. DONE waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (release_result) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture and serial datapath. Operands are copied into local
  // registers at capture, so later changes on a/b have no effect. The
  // borrow register is seeded with borrow_in. The result registers change
  // only while shifting, so they stay stable in DONE under backpressure.
  // The final borrow and the overflow flag are registered on the MSB edge.
  // The MSB difference bit is still combinational at that point, so the
  // overflow flag uses the cell output directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      br_q       <= 1'b0;
      idx_q      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (capture) begin
        a_q   <= a;
        b_q   <= b;
        br_q  <= borrow_in;
        idx_q <= '0;
      end else if (state_q == SHIFT) begin
        diff[idx_q] <= cell_diff;
        br_q        <= cell_borrow;
        idx_q       <= idx_q + 1'b1;
        if (last_bit) begin
          borrow_out <= cell_borrow;
          overflow   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                        (cell_diff ^ a_q[WIDTH-1]);
        end
      end
    end
  end

endmodule : serial_subtractor
